reg_dump_scanner: RTL and testbench
===================================

Name: reg_dump_scanner

Overview:
- Reader-side master for the CPU debug register port. It drives the Regin select and samples the returned Regout word.
- On a start pulse it walks register indices FIRST_REG..LAST_REG. For each index it waits a settle window, captures the word, and presents it on a valid/ready output stream tagged with its index.
- It keeps a running XOR checksum of all captured words.
- It sits beside the processor top level, clocked by the fast CLOCK. It feeds a future UART/display dumper.

Parameters:
- SETTLE_CYCLES, 2, cycles to wait after changing oRegin before sampling iRegout; legal range 1..15.
- FIRST_REG, 0, first register index scanned.
- LAST_REG, 31, last register index scanned; must be >= FIRST_REG.

Ports:
- CLOCK  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- iStart  input  1  begin a scan; sampled only when not busy.
- oRegin  output  5  register select driven to the CPU Regin port.
- iRegout  input  32  register value returned by the CPU for oRegin.
- oData  output  32  captured register word.
- oIndex  output  5  register index of oData.
- oValid  output  1  oData/oIndex valid.
- iReady  input  1  consumer accepts the word on a cycle where oValid and iReady are both 1.
- oBusy  output  1  scan in progress.
- oDone  output  1  sticky high after the last word is accepted; cleared by the next accepted iStart or by reset.
- oChecksum  output  32  XOR of all words captured in the current or last scan.

Behaviour:
- Reset (Reset==0 at a rising edge), applied from any state including mid-scan:
  - state IDLE, oRegin=FIRST_REG, oData=0, oIndex=0.
  - oValid=0, oBusy=0, oDone=0, oChecksum=0, settle counter=0.
  - A word pending on the output is dropped.
- States: IDLE, SETTLE, CAPTURE, SEND.
- IDLE:
  - oBusy=0.
  - iStart=1 → oRegin<=FIRST_REG, cnt<=0, oChecksum<=0, oDone<=0, next state SETTLE.
- SETTLE:
  - oBusy=1, oRegin held stable.
  - cnt increments each cycle; when cnt==SETTLE_CYCLES-1, next state CAPTURE.
- CAPTURE, one cycle:
  - oData<=iRegout, oIndex<=oRegin, oValid<=1, oChecksum<=oChecksum^iRegout.
  - Next state SEND.
- SEND:
  - oData, oIndex and oValid are held stable while iReady=0; there is no timeout.
  - On oValid&iReady: oValid<=0.
  - If oRegin==LAST_REG, set oDone<=1 and go to IDLE.
  - Otherwise oRegin<=oRegin+1, cnt<=0, go to SETTLE.
- iStart is ignored in SETTLE, CAPTURE and SEND.
- iStart is accepted in IDLE even when oDone=1; this restarts the scan and clears oDone and oChecksum.
- Latency:
  - The first oValid rises SETTLE_CYCLES+1 edges after the edge that samples iStart.
  - With iReady tied high, each register takes SETTLE_CYCLES+2 cycles.
  - A full scan takes (LAST_REG-FIRST_REG+1)*(SETTLE_CYCLES+2) cycles: 128 for the defaults.
- oRegin changes only on SETTLE entry; it never changes while in SETTLE or CAPTURE.
- oRegin arithmetic is 5-bit. LAST_REG ≤ 31 guarantees no wrap within a scan.
- Scan end: oRegin stays at LAST_REG after the scan finishes and returns to FIRST_REG only on the next start.
- Atomicity: the scan is not atomic with respect to CPU writes. Each word reflects iRegout at its own CAPTURE cycle.
- x0 is captured like any other register; the CPU supplies 0.

Test Plan:
- Reset mid-scan: start a scan; assert Reset=0 for 1 cycle while in SEND with oIndex=5 → oValid=0, oBusy=0, oRegin=0, oChecksum=0, oDone=0 next cycle. No further words appear until a new iStart.
- Full dump, ready high:
  - Stimulus: bench models the register file with reg[i]=i*0x11111111 (mod 2^32); iReady=1; iStart pulse.
  - Expected words: 32 words with oIndex 0..31 and oData matching the model.
  - Expected timing: first oValid 3 cycles after iStart; oDone rises after 128 cycles.
  - Expected checksum: oChecksum equals the XOR of the 32 model values.
- Backpressure: iReady=0 for 10 cycles while oValid=1 at oIndex=7 → oData and oIndex stay stable, oRegin stays 7. The single handshake on iReady=1 moves to index 8. No word is duplicated or skipped.
- Settle honoured:
  - Stimulus: SETTLE_CYCLES=4; bench returns iRegout only 3 cycles after oRegin changes and 0xDEADBEEF before that.
  - Expected: no captured word equals 0xDEADBEEF; per-register period is 6 cycles with iReady=1.
- Start handling:
  - iStart held high throughout the scan → no restart while busy.
  - A new scan begins immediately after oDone rises, with oDone and oChecksum cleared the cycle after acceptance.
- Partial range: FIRST_REG=10, LAST_REG=12 → exactly 3 words with oIndex 10, 11, 12, then oDone=1 and oRegin=12.

Source files
------------

// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner
// Reader-side master for the CPU debug register port. On a start pulse it
// walks register indices FIRST_REG..LAST_REG. For each index it drives the
// select, waits a settle window, captures the returned word and offers it on
// a valid/ready stream tagged with its index. A running XOR checksum of the
// words captured in the current (or last) scan is kept alongside.
//
// Ports:
//   CLOCK     in   1   system clock, rising edge active
//   Reset     in   1   synchronous, active-low reset
//   iStart    in   1   begin a scan (only looked at while idle)
//   oRegin    out  5   register select to the CPU Regin port
//   iRegout   in  32   register value returned by the CPU for oRegin
//   oData     out 32   captured register word
//   oIndex    out  5   register index of oData
//   oValid    out  1   oData/oIndex valid
//   iReady    in   1   consumer accepts the word when oValid && iReady
//   oBusy     out  1   scan in progress
//   oDone     out  1   sticky, set after the last word is accepted
//   oChecksum out 32   XOR of all words captured in the current/last scan
module reg_dump_scanner #(
  parameter int unsigned SETTLE_CYCLES = 2,   // legal range 1..15
  parameter int unsigned FIRST_REG     = 0,
  parameter int unsigned LAST_REG      = 31   // must be >= FIRST_REG
) (
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic        iStart,
  output logic [4:0]  oRegin,
  input  logic [31:0] iRegout,
  output logic [31:0] oData,
  output logic [4:0]  oIndex,
  output logic        oValid,
  input  logic        iReady,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oChecksum
);

  localparam logic [4:0] FIRST_IDX   = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX    = 5'(LAST_REG);
  // Settle counter terminal value; the counter starts at 0 on SETTLE entry,
  // so SETTLE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_t;

  state_t     state_r;
  logic [3:0] cnt_r;

  // Checksum accumulation step for one captured word.
  function automatic logic [31:0] fold_checksum(input logic [31:0] acc,
                                                input logic [31:0] word);
    return acc ^ word;
  endfunction

  // Scan sequencer: state, settle counter and all registered outputs.
  always_ff @(posedge CLOCK) begin
    if (!Reset) begin
      // Reset wins from any state; a word pending on the output is dropped.
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      oRegin    <= FIRST_IDX;
      oData     <= 32'd0;
      oIndex    <= 5'd0;
      oValid    <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oChecksum <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          // A start is taken even with oDone set: that is a restart.
          if (iStart) begin
            oRegin    <= FIRST_IDX;
            cnt_r     <= 4'd0;
            oChecksum <= 32'd0;
            oDone     <= 1'b0;
            oBusy     <= 1'b1;
            state_r   <= SETTLE;
          end else begin
            oBusy     <= 1'b0;
          end
        end

        SETTLE: begin
          // oRegin is held here so the CPU read path can settle.
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == SETTLE_LAST) begin
            state_r <= CAPTURE;
          end else begin
            state_r <= SETTLE;
          end
        end

        CAPTURE: begin
          oData     <= iRegout;
          oIndex    <= oRegin;
          oValid    <= 1'b1;
          oChecksum <= fold_checksum(oChecksum, iRegout);
          state_r   <= SEND;
        end

        SEND: begin
          // Word held stable until the consumer takes it; no timeout.
          if (oValid && iReady) begin
            oValid <= 1'b0;
            if (oRegin == LAST_IDX) begin
              // oRegin intentionally stays at LAST_REG after the scan.
              oDone   <= 1'b1;
              oBusy   <= 1'b0;
              state_r <= IDLE;
            end else begin
              oRegin  <= oRegin + 5'd1;
              cnt_r   <= 4'd0;
              state_r <= SETTLE;
            end
          end else begin
            state_r <= SEND;
          end
        end

        default: begin
          state_r <= IDLE;
          oValid  <= 1'b0;
          oBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Self-checking bench for reg_dump_scanner: a default-parameter instance for
// the main scenarios, a SETTLE_CYCLES=4 instance fed with a slow read path,
// and a FIRST_REG=10..LAST_REG=12 instance for the partial range.
module tb_reg_dump_scanner;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } word_t;

  typedef struct {
    int          idx;
    logic [31:0] exp;
  } spot_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic CLOCK = 1'b0;
  logic Reset;
  always #5 CLOCK = ~CLOCK;

  // ---------------- main instance (defaults) ----------------
  logic        m_start, m_ready, m_valid, m_busy, m_done;
  logic [4:0]  m_regin, m_index;
  logic [31:0] m_regout, m_data, m_sum;
  logic [31:0] regfile [32];
  assign m_regout = regfile[m_regin];

  reg_dump_scanner u_main (
    .CLOCK(CLOCK), .Reset(Reset), .iStart(m_start), .oRegin(m_regin),
    .iRegout(m_regout), .oData(m_data), .oIndex(m_index), .oValid(m_valid),
    .iReady(m_ready), .oBusy(m_busy), .oDone(m_done), .oChecksum(m_sum)
  );

  // ---------------- slow-read instance (SETTLE_CYCLES=4) ----------------
  logic        s_start, s_ready, s_valid, s_busy, s_done;
  logic [4:0]  s_regin, s_index;
  logic [31:0] s_regout, s_data, s_sum;
  int          age = 0;
  logic [4:0]  s_prev_regin;
  logic        s_prev_busy = 1'b0;
  logic        s_prev_valid = 1'b0;
  // Read path returns garbage until 3 cycles after the select changes.
  assign s_regout = (age < 3) ? 32'hDEADBEEF : (pat(s_regin) + 32'd1);

  reg_dump_scanner #(.SETTLE_CYCLES(4)) u_settle (
    .CLOCK(CLOCK), .Reset(Reset), .iStart(s_start), .oRegin(s_regin),
    .iRegout(s_regout), .oData(s_data), .oIndex(s_index), .oValid(s_valid),
    .iReady(s_ready), .oBusy(s_busy), .oDone(s_done), .oChecksum(s_sum)
  );

  // ---------------- partial-range instance ----------------
  logic        p_start, p_ready, p_valid, p_busy, p_done;
  logic [4:0]  p_regin, p_index;
  logic [31:0] p_regout, p_data, p_sum;
  assign p_regout = pat(p_regin);

  reg_dump_scanner #(.FIRST_REG(10), .LAST_REG(12)) u_part (
    .CLOCK(CLOCK), .Reset(Reset), .iStart(p_start), .oRegin(p_regin),
    .iRegout(p_regout), .oData(p_data), .oIndex(p_index), .oValid(p_valid),
    .iReady(p_ready), .oBusy(p_busy), .oDone(p_done), .oChecksum(p_sum)
  );

  word_t m_q[$];
  word_t s_q[$];
  word_t p_q[$];
  int    s_rise[$];

  function automatic logic [31:0] pat(input logic [4:0] i);
    logic [31:0] w;
    w = {27'd0, i};
    return w * 32'h11111111;
  endfunction

  // Stream monitors: inputs change just after posedge, so values seen at
  // negedge are exactly the ones the next rising edge will act on.
  always @(negedge CLOCK) begin
    cyc++;
    if (Reset && m_valid && m_ready) m_q.push_back(word_t'{m_index, m_data});
    if (Reset && s_valid && s_ready) s_q.push_back(word_t'{s_index, s_data});
    if (Reset && p_valid && p_ready) p_q.push_back(word_t'{p_index, p_data});
    if (s_valid && !s_prev_valid) s_rise.push_back(cyc);
    s_prev_valid = s_valid;
    if ((s_regin !== s_prev_regin) || (s_busy && !s_prev_busy)) age = 0;
    else if (age < 1000) age++;
    s_prev_regin = s_regin;
    s_prev_busy  = s_busy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic m_pulse_start();
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
  endtask

  task automatic m_wait_done(input string name, input int bound);
    for (int k = 0; k < bound && !m_done; k++) tick();
    chk(name, {31'd0, m_done}, 32'd1);
  endtask

  spot_t tbl[6];
  logic [31:0] model_sum;
  int first_v, done_at, bad;

  initial begin
    // Spot values of reg[i] = i*0x11111111 (mod 2^32), worked out by hand.
    tbl[0] = '{0,  32'h00000000};
    tbl[1] = '{1,  32'h11111111};
    tbl[2] = '{7,  32'h77777777};
    tbl[3] = '{15, 32'hFFFFFFFF};
    tbl[4] = '{16, 32'h11111110};
    tbl[5] = '{31, 32'h1111110F};

    Reset = 1'b0;
    m_start = 1'b0; s_start = 1'b0; p_start = 1'b0;
    m_ready = 1'b1; s_ready = 1'b1; p_ready = 1'b1;
    for (int i = 0; i < 32; i++) regfile[i] = pat(5'(i));
    repeat (3) tick();
    Reset = 1'b1;
    tick();

    // ---- reset state ----
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_busy",  {31'd0, m_busy},  32'd0);
    chk("rst_done",  {31'd0, m_done},  32'd0);
    chk("rst_regin", {27'd0, m_regin}, 32'd0);
    chk("rst_data",  m_data, 32'd0);
    chk("rst_index", {27'd0, m_index}, 32'd0);
    chk("rst_sum",   m_sum, 32'd0);

    // ---- full dump, ready high ----
    m_q.delete();
    m_pulse_start();
    first_v = -1; done_at = -1;
    for (int k = 1; k <= 400 && done_at < 0; k++) begin
      tick();
      if (m_valid && first_v < 0) first_v = k;
      if (m_done) done_at = k;
    end
    chk("first_valid_latency", first_v, 32'd3);
    chk("scan_cycles", done_at, 32'd128);
    chk("dump_count", m_q.size(), 32'd32);
    model_sum = 32'd0;
    for (int i = 0; i < 32; i++) begin
      model_sum ^= pat(5'(i));
      chk($sformatf("dump_idx[%0d]", i),  {27'd0, m_q[i].idx}, i);
      chk($sformatf("dump_data[%0d]", i), m_q[i].data, pat(5'(i)));
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("spot_reg%0d", tbl[i].idx), m_q[tbl[i].idx].data, tbl[i].exp);
    chk("dump_checksum", m_sum, model_sum);
    chk("end_regin", {27'd0, m_regin}, 32'd31);
    chk("end_busy", {31'd0, m_busy}, 32'd0);

    // ---- start held high: no restart while busy, restart right after done ----
    m_q.delete();
    m_start = 1'b1;
    tick();
    m_wait_done("hold_start_done", 400);
    chk("hold_start_count", m_q.size(), 32'd32);
    bad = 0;
    for (int i = 0; i < m_q.size(); i++) if (m_q[i].idx != 5'(i)) bad++;
    chk("hold_start_order", bad, 32'd0);
    chk("done_busy_low", {31'd0, m_busy}, 32'd0);
    tick();
    m_start = 1'b0;
    chk("restart_done_clr", {31'd0, m_done}, 32'd0);
    chk("restart_sum_clr",  m_sum, 32'd0);
    chk("restart_busy",     {31'd0, m_busy}, 32'd1);
    chk("restart_regin",    {27'd0, m_regin}, 32'd0);
    m_wait_done("restart_scan_done", 400);

    // ---- backpressure at index 7 ----
    m_q.delete();
    m_pulse_start();
    for (int k = 0; k < 200; k++) begin
      tick();
      if (m_valid && m_index == 5'd7) begin
        m_ready = 1'b0;
        break;
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("bp_valid[%0d]", c), {31'd0, m_valid}, 32'd1);
      chk($sformatf("bp_index[%0d]", c), {27'd0, m_index}, 32'd7);
      chk($sformatf("bp_data[%0d]", c),  m_data, regfile[7]);
      chk($sformatf("bp_regin[%0d]", c), {27'd0, m_regin}, 32'd7);
    end
    m_ready = 1'b1;
    tick();
    chk("bp_accept_valid", {31'd0, m_valid}, 32'd0);
    for (int k = 0; k < 20 && !m_valid; k++) tick();
    chk("bp_next_index", {27'd0, m_index}, 32'd8);
    m_wait_done("bp_done", 400);
    chk("bp_count", m_q.size(), 32'd32);
    bad = 0;
    for (int i = 0; i < m_q.size(); i++) if (m_q[i].idx != 5'(i)) bad++;
    chk("bp_order", bad, 32'd0);

    // ---- randomized register file and random backpressure ----
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    regfile[0] = 32'd0;
    m_q.delete();
    m_pulse_start();
    for (int k = 0; k < 3000 && !m_done; k++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready = 1'b1;
    chk("rand_done", {31'd0, m_done}, 32'd1);
    chk("rand_count", m_q.size(), 32'd32);
    model_sum = 32'd0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      model_sum ^= regfile[i];
      if (m_q[i].idx != 5'(i) || m_q[i].data != regfile[i]) bad++;
    end
    chk("rand_words", bad, 32'd0);
    chk("rand_checksum", m_sum, model_sum);

    // ---- reset mid-scan while holding index 5 ----
    for (int i = 0; i < 32; i++) regfile[i] = pat(5'(i));
    m_pulse_start();
    for (int k = 0; k < 200; k++) begin
      tick();
      if (m_valid && m_index == 5'd5) begin
        m_ready = 1'b0;
        break;
      end
    end
    tick();
    chk("pre_rst_index", {27'd0, m_index}, 32'd5);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_busy",  {31'd0, m_busy},  32'd0);
    chk("mid_rst_regin", {27'd0, m_regin}, 32'd0);
    chk("mid_rst_sum",   m_sum, 32'd0);
    chk("mid_rst_done",  {31'd0, m_done},  32'd0);
    m_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_valid || m_busy) bad++;
    end
    chk("mid_rst_quiet", bad, 32'd0);

    // ---- settle window honoured (SETTLE_CYCLES=4) ----
    s_q.delete();
    s_rise.delete();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int k = 0; k < 600 && !s_done; k++) tick();
    chk("settle_done", {31'd0, s_done}, 32'd1);
    chk("settle_count", s_q.size(), 32'd32);
    bad = 0;
    for (int i = 0; i < s_q.size(); i++)
      if (s_q[i].data == 32'hDEADBEEF || s_q[i].data != pat(5'(i)) + 32'd1) bad++;
    chk("settle_words", bad, 32'd0);
    chk("settle_rises", s_rise.size(), 32'd32);
    bad = 0;
    for (int j = 1; j < s_rise.size(); j++) if (s_rise[j] - s_rise[j-1] != 6) bad++;
    chk("settle_period", bad, 32'd0);

    // ---- partial range 10..12 ----
    p_q.delete();
    p_start = 1'b1;
    tick();
    p_start = 1'b0;
    for (int k = 0; k < 100 && !p_done; k++) tick();
    chk("part_done", {31'd0, p_done}, 32'd1);
    chk("part_count", p_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("part_idx[%0d]", i),  {27'd0, p_q[i].idx}, 10 + i);
      chk($sformatf("part_data[%0d]", i), p_q[i].data, pat(5'(10 + i)));
    end
    chk("part_regin", {27'd0, p_regin}, 32'd12);
    chk("part_checksum", p_sum, pat(5'd10) ^ pat(5'd11) ^ pat(5'd12));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
